alu_arbiter: RTL
================

# alu_arbiter

Two-port arbiter and sequencer that shares the single combinational ALU between two requesters, e.g. port 0 = main execute stage and port 1 = address/branch helper. Accepts one operation at a time through a valid/ready handshake, using round-robin selection. Drives the ALU operand and control inputs from registers, then captures `alu_result` and `zero` into a response register. Holds the response until the granted requester accepts it.

## Interface
- `DATA_W`, 32, operand/result width
- `CTRL_W`, 4, ALU control code width
- `SHAMT_W`, 5, shift-amount width
- `clk` in 1: single clock, all state on rising edge
- `rst` in 1: synchronous, active-high reset
- `req_valid[1:0]` in 2: per-port request valid
- `req_ready[1:0]` out 2: per-port request accepted this cycle
- `req0_ctrl`, `req1_ctrl` in CTRL_W: ALU op code (AND=0000, OR=0001, ADD=0010, XOR=0011, SLL=0100, SGT=0101, SUB=0110, SLT=0111, SRL=1000, SRA=1001, LUI=1010, NOR=1100)
- `req0_a`, `req1_a` in DATA_W: first operand (rs)
- `req0_b`, `req1_b` in DATA_W: second operand (rt/immediate)
- `req0_shamt`, `req1_shamt` in SHAMT_W: shift amount
- `rsp_valid[1:0]` out 2: per-port response valid (at most one bit set)
- `rsp_ready[1:0]` in 2: per-port response accept
- `rsp_result` out DATA_W: captured ALU result, shared by both ports
- `rsp_zero` out 1: captured ALU zero flag
- `alu_ctrl` out CTRL_W: to ALU control input
- `alu_a` out DATA_W: to ALU first operand
- `alu_b` out DATA_W: to ALU second operand
- `alu_shamt` out SHAMT_W: to ALU shift-amount input
- `alu_result` in DATA_W: from ALU
- `alu_zero` in 1: from ALU
- `busy` out 1: high whenever state ≠ IDLE

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE
  - `req_ready[i]` = `grant_i`, computed combinationally from `req_valid` and `last_grant`.
  - Only one valid request: that port is granted.
  - Both valid: the port ≠ `last_grant` is granted.
  - On a handshake, latch ctrl/a/b/shamt of the granted port into the operand registers, record `owner`, set `last_grant` = `owner`, and go to EXEC.
- EXEC (exactly one cycle)
  - Operand registers drive the ALU, which settles combinationally.
  - At the clock edge, `alu_result` → `rsp_result` and `alu_zero` → `rsp_zero`; go to RESP.
- RESP
  - `rsp_valid[owner]` = 1.
  - When `rsp_ready[owner]` = 1, go to IDLE at that edge.
  - `rsp_ready` of the other port is ignored.
- Idle drive: in IDLE and RESP the ALU inputs are `alu_ctrl` = 4'b1011 (unused code, ALU outputs 0) and `alu_a` = `alu_b` = 0, `alu_shamt` = 0. This keeps ALU activity quiet.
- Requests are not queued. A port's request data must be held stable while `req_valid` is high and not yet accepted.
- The block performs no arithmetic; widths pass through unchanged, and signedness is the ALU's concern.
- Invalid `ctrl` codes (1011, 1101–1111) are forwarded as-is; the ALU returns result 0 and zero 0.

## Timing
- Reset values: state = IDLE, `req_ready` = 00, `rsp_valid` = 00, `rsp_result` = 0, `rsp_zero` = 0, `busy` = 0, operand registers = 0, `alu_ctrl` = 1011, `last_grant` = 1 (so port 0 wins the first tie).
- Latency: handshake at edge T → ALU driven during cycle T+1 → `rsp_valid` high from edge T+2.
- Zero-stall throughput: one operation per 3 cycles, since a new grant is possible in the cycle after response acceptance.
- `req_ready` is never high outside IDLE and is never high on both ports at once.
- `rsp_valid` stays asserted, with `rsp_result`/`rsp_zero` stable, until accepted; no timeout.
- Simultaneous events:
  - A request arriving while busy waits; it is not dropped and never preempts.
  - Both ports valid on consecutive transactions: grants alternate 0,1,0,1.
- Reset mid-operation (EXEC or RESP): the transaction is discarded and all outputs return to reset values on the reset edge, with no response issued.
- `rst` has priority over all handshakes in the same cycle.

## Test plan
- Single op: port 0 ADD, a=5, b=7 → `req_ready[0]` same cycle, `rsp_valid` = 01 two edges later, `rsp_result` = 12, `rsp_zero` = 0.
- Zero flag and backpressure: port 1 SUB 9−9 with `rsp_ready[1]` held low 4 cycles → `rsp_valid` = 10 held 4+ cycles, result 0, `rsp_zero` = 1. Port 0 request raised meanwhile gets no `req_ready` until after acceptance.
- Round robin: both ports valid continuously (port 0 SLL b=1 shamt=4; port 1 LUI b=0x0003) → grant order 0,1,0,1, results 16 and 0x00030000, first grant to port 0 after reset.
- Signed compare: port 0 SLT a=−1, b=1 → result 1; then SGT same operands → result 0; then SRA b=0x80000000 shamt=31 → 0xFFFFFFFF.
- Reset mid-op: assert `rst` during EXEC, then during RESP → `rsp_valid` = 00, `busy` = 0, `alu_ctrl` = 1011 next cycle. A following port 1 request is granted normally.
- Invalid code: ctrl 1110, a=3, b=4 → `rsp_result` = 0, `rsp_zero` = 0, FSM returns to IDLE normally.

Source files
------------

// File: rtl/alu_arbiter.sv
// Two-port round-robin arbiter that time-shares one combinational ALU.
// One operation in flight: IDLE (grant) -> EXEC (ALU settles) -> RESP (hold until accepted).
module alu_arbiter #(
  parameter int DATA_W  = 32,
  parameter int CTRL_W  = 4,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         req_valid,
  output logic [1:0]         req_ready,
  input  logic [CTRL_W-1:0]  req0_ctrl,
  input  logic [CTRL_W-1:0]  req1_ctrl,
  input  logic [DATA_W-1:0]  req0_a,
  input  logic [DATA_W-1:0]  req1_a,
  input  logic [DATA_W-1:0]  req0_b,
  input  logic [DATA_W-1:0]  req1_b,
  input  logic [SHAMT_W-1:0] req0_shamt,
  input  logic [SHAMT_W-1:0] req1_shamt,
  output logic [1:0]         rsp_valid,
  input  logic [1:0]         rsp_ready,
  output logic [DATA_W-1:0]  rsp_result,
  output logic               rsp_zero,
  output logic [CTRL_W-1:0]  alu_ctrl,
  output logic [DATA_W-1:0]  alu_a,
  output logic [DATA_W-1:0]  alu_b,
  output logic [SHAMT_W-1:0] alu_shamt,
  input  logic [DATA_W-1:0]  alu_result,
  input  logic               alu_zero,
  output logic               busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  // Unused opcode: the ALU outputs 0 for it, keeping the datapath quiet.
  localparam logic [CTRL_W-1:0] CTRL_QUIET = CTRL_W'(11);

  state_t               state_reg, state_next;
  logic                 owner_reg;
  logic                 last_grant_reg;
  logic [CTRL_W-1:0]    ctrl_reg;
  logic [DATA_W-1:0]    a_reg;
  logic [DATA_W-1:0]    b_reg;
  logic [SHAMT_W-1:0]   shamt_reg;
  logic [DATA_W-1:0]    rsp_result_reg;
  logic                 rsp_zero_reg;

  logic [1:0]           grant;
  logic                 grant_port;
  logic                 handshake;

  logic [CTRL_W-1:0]    port_ctrl  [2];
  logic [DATA_W-1:0]    port_a     [2];
  logic [DATA_W-1:0]    port_b     [2];
  logic [SHAMT_W-1:0]   port_shamt [2];

  assign port_ctrl[0]  = req0_ctrl;
  assign port_ctrl[1]  = req1_ctrl;
  assign port_a[0]     = req0_a;
  assign port_a[1]     = req1_a;
  assign port_b[0]     = req0_b;
  assign port_b[1]     = req1_b;
  assign port_shamt[0] = req0_shamt;
  assign port_shamt[1] = req1_shamt;

  // On a tie the port that did not win last time gets the grant.
  always_comb begin
    grant = 2'b00;
    if (state_reg == IDLE) begin
      case (req_valid)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = last_grant_reg ? 2'b01 : 2'b10;
        default: grant = 2'b00;
      endcase
    end
  end

  assign grant_port = grant[1];
  assign handshake  = |grant;
  assign req_ready  = grant;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (handshake) state_next = EXEC;
      EXEC:    state_next = RESP;
      RESP:    if (rsp_ready[owner_reg]) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      owner_reg      <= 1'b0;
      last_grant_reg <= 1'b1;
      ctrl_reg       <= '0;
      a_reg          <= '0;
      b_reg          <= '0;
      shamt_reg      <= '0;
      rsp_result_reg <= '0;
      rsp_zero_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (state_reg == IDLE && handshake) begin
        owner_reg      <= grant_port;
        last_grant_reg <= grant_port;
        ctrl_reg       <= port_ctrl[grant_port];
        a_reg          <= port_a[grant_port];
        b_reg          <= port_b[grant_port];
        shamt_reg      <= port_shamt[grant_port];
      end
      if (state_reg == EXEC) begin
        rsp_result_reg <= alu_result;
        rsp_zero_reg   <= alu_zero;
      end
    end
  end

  // Operands reach the ALU only during EXEC.
  always_comb begin
    alu_ctrl  = CTRL_QUIET;
    alu_a     = '0;
    alu_b     = '0;
    alu_shamt = '0;
    if (state_reg == EXEC) begin
      alu_ctrl  = ctrl_reg;
      alu_a     = a_reg;
      alu_b     = b_reg;
      alu_shamt = shamt_reg;
    end
  end

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_rsp
      assign rsp_valid[gi] = (state_reg == RESP) && (owner_reg == 1'(gi));
    end
  endgenerate

  assign rsp_result = rsp_result_reg;
  assign rsp_zero   = rsp_zero_reg;
  assign busy       = (state_reg != IDLE);

endmodule
